dec_3to8: RTL and testbench
===========================

// Module: dec_3to8
//
// PURPOSE
// - Registered 3-to-8 line decoder: the 3-bit code {x,y,z} selects exactly one of eight one-hot outputs D[7:0].
// - Used as a generic select/enable generator wherever a binary code must drive one-hot chip/row selects.
// - Output is registered on clk, giving one cycle of latency, and has a synchronous enable.
//
// PARAMETERS
// - ACTIVE_LOW  default 0  0: selected line = 1, others = 0. 1: all D bits and the idle value are inverted (selected line = 0, others = 1).
//
// PORTS
// - clk    in   1  system clock; all state updates on the rising edge
// - rst    in   1  synchronous reset, active-high
// - en     in   1  decode enable; sampled on the rising clk edge
// - x      in   1  code bit 2 (MSB)
// - y      in   1  code bit 1
// - z      in   1  code bit 0 (LSB)
// - D      out  8  registered one-hot decode; D[k] is asserted when {x,y,z} == k
// - valid  out  1  registered; 1 when D holds a decode result, 0 when D is idle
//
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - Code: k = {x,y,z}, unsigned 0..7. x is the MSB and z is the LSB.
// - Idle value: IDLE = 8'h00 when ACTIVE_LOW=0, and 8'hFF when ACTIVE_LOW=1.
// - Reset: when rst=1 at a rising edge, D <= IDLE and valid <= 0. Reset takes priority over en and the inputs.
// - Decode (rst=0, en=1): D <= (8'h01 << k), XORed with 8'hFF when ACTIVE_LOW=1; valid <= 1.
// - Disabled (rst=0, en=0): D <= IDLE and valid <= 0. D does not hold its previous decode.
// - Latency: exactly one clk cycle from sampled inputs to D and valid. There is no combinational path from inputs to outputs.
// - Exactly one D bit is in the asserted state whenever valid=1. No D bit is asserted whenever valid=0.
// - Back-to-back input changes on consecutive cycles each produce their own decode on the following cycle. There is no throttling.
// - Reset asserted mid-stream: the output returns to IDLE on that edge. The first decode after reset release appears one cycle after the first edge with rst=0 and en=1.
// - Inputs x, y, z and en are synchronous to clk. No X-propagation masking is required.
//
// CONFIGURATION
// - Macro DEC_3TO8_IDX_EN, when defined:
//   - adds output port idx [2:0], a registered copy of {x,y,z};
//   - idx updates under the same rules as D: reset value 3'b000, and it loads 3'b000 when en=0;
//   - the invariant D == (8'h01 << idx) holds whenever valid=1 and ACTIVE_LOW=0.
// - Macro undefined: the idx port and its register are absent. All other behaviour is identical.
//
// TESTING
// 1. Hold rst=1 for 2 cycles with en=1 and {x,y,z}=3'b101 -> D=8'h00 and valid=0 throughout. Release rst -> next cycle D=8'h20, valid=1.
// 2. With en=1, sweep {x,y,z} 000..111, changing each cycle -> one cycle later D = 01,02,04,08,10,20,40,80 in sequence, valid=1.
// 3. With en=1, apply {x,y,z}=3'b011, then drop en to 0 -> D=8'h08 and valid=1, then next cycle D=8'h00 and valid=0.
// 4. Assert rst while decoding 3'b111 (D=8'h80) -> on the next edge D=8'h00 and valid=0. After release, decode resumes with 1-cycle latency.
// 5. With ACTIVE_LOW=1, apply {x,y,z}=3'b010 and en=1 -> D=8'hFB, valid=1. With rst=1 -> D=8'hFF.
// 6. With DEC_3TO8_IDX_EN defined, sweep all 8 codes -> idx tracks the code with 1-cycle latency. Check D == 1<<idx every valid cycle.

Source files
------------

// File: rtl/dec_3to8.sv
`default_nettype none
// ============================================================================
// Module      : dec_3to8
// Description : Registered 3-to-8 one-hot decoder with synchronous enable and
//               optional active-low output polarity. Defining DEC_3TO8_IDX_EN
//               adds a registered copy of the decoded code on port idx.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_3to8 #(
    parameter int ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       x,
    input  logic       y,
    input  logic       z,
    output logic [7:0] D,
    output logic       valid
`ifdef DEC_3TO8_IDX_EN
    ,
    output logic [2:0] idx
`endif
);

    // Polarity is applied by XOR with the idle pattern, so the idle value and
    // the inversion mask are the same constant.
    localparam logic [7:0] C_IDLE = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [2:0] w_code;
    logic [7:0] d_d;
    logic [7:0] d_q;
    logic       valid_d;
    logic       valid_q;

    assign w_code = {x, y, z};

    always_comb begin
        d_d     = C_IDLE;
        valid_d = 1'b0;
        if (en) begin
            d_d     = (8'h01 << w_code) ^ C_IDLE;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q     <= C_IDLE;
            valid_q <= 1'b0;
        end else begin
            d_q     <= d_d;
            valid_q <= valid_d;
        end
    end

    assign D     = d_q;
    assign valid = valid_q;

`ifdef DEC_3TO8_IDX_EN
    logic [2:0] idx_d;
    logic [2:0] idx_q;

    always_comb begin
        idx_d = 3'b000;
        if (en) begin
            idx_d = w_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 3'b000;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dec_3to8.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec_3to8
// Description : Scoreboard bench for dec_3to8, both output polarities driven
//               from shared stimulus. Exercises idx when DEC_3TO8_IDX_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec_3to8;

    logic       clk;
    logic       rst;
    logic       en;
    logic       x;
    logic       y;
    logic       z;
    logic [7:0] d_hi;
    logic       v_hi;
    logic [7:0] d_lo;
    logic       v_lo;
`ifdef DEC_3TO8_IDX_EN
    logic [2:0] idx_hi;
    logic [2:0] idx_lo;
`endif

    int n_cmp;
    int n_err;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
        logic [7:0] dal;
        logic [2:0] idx;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;

    dec_3to8 #(.ACTIVE_LOW(0)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .x     (x),
        .y     (y),
        .z     (z),
        .D     (d_hi),
        .valid (v_hi)
`ifdef DEC_3TO8_IDX_EN
        ,
        .idx   (idx_hi)
`endif
    );

    dec_3to8 #(.ACTIVE_LOW(1)) dut_al (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .x     (x),
        .y     (y),
        .z     (z),
        .D     (d_lo),
        .valid (v_lo)
`ifdef DEC_3TO8_IDX_EN
        ,
        .idx   (idx_lo)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic r, input logic e, input logic [2:0] code);
        exp_t t;
        if (r || !e) begin
            t.d   = 8'h00;
            t.v   = 1'b0;
            t.idx = 3'b000;
        end else begin
            t.d   = 8'h01 << code;
            t.v   = 1'b1;
            t.idx = code;
        end
        t.dal = ~t.d;
        return t;
    endfunction

    // Drive one cycle of stimulus, confirm outputs hold before the edge, then
    // check the registered result one cycle later.
    task automatic step(input logic r, input logic e, input logic [2:0] code, input string tag);
        exp_t t;
        @(negedge clk);
        rst = r;
        en  = e;
        {x, y, z} = code;
        sb.push_back(model(r, e, code));
        if (last_exp.v !== 1'bx) begin
            #1;
            chk({tag, ":hold_D"}, {24'h0, d_hi}, {24'h0, last_exp.d});
        end
        @(posedge clk);
        #1;
        t = sb.pop_front();
        chk({tag, ":D"},      {24'h0, d_hi}, {24'h0, t.d});
        chk({tag, ":valid"},  {31'h0, v_hi}, {31'h0, t.v});
        chk({tag, ":D_al"},   {24'h0, d_lo}, {24'h0, t.dal});
        chk({tag, ":valid_al"}, {31'h0, v_lo}, {31'h0, t.v});
`ifdef DEC_3TO8_IDX_EN
        chk({tag, ":idx"},    {29'h0, idx_hi}, {29'h0, t.idx});
        chk({tag, ":idx_al"}, {29'h0, idx_lo}, {29'h0, t.idx});
        if (v_hi === 1'b1)
            chk({tag, ":D_vs_idx"}, {24'h0, d_hi}, {24'h0, 8'h01 << idx_hi});
`endif
        last_exp = t;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        en  = 1'b0;
        {x, y, z} = 3'b000;
        last_exp = 'x;

        // Reset held with en=1 and code 101; release gives 0x20.
        step(1'b1, 1'b1, 3'b101, "rst1");
        step(1'b1, 1'b1, 3'b101, "rst2");
        step(1'b0, 1'b1, 3'b101, "rel");

        // Full sweep back to back.
        for (int k = 0; k < 8; k++)
            step(1'b0, 1'b1, 3'(k), "sweep");

        // Enable drop: output goes idle rather than holding.
        step(1'b0, 1'b1, 3'b011, "en_on");
        step(1'b0, 1'b0, 3'b011, "en_off");
        step(1'b0, 1'b0, 3'b110, "en_off2");

        // Reset mid-stream, then resume.
        step(1'b0, 1'b1, 3'b111, "pre_rst");
        step(1'b1, 1'b1, 3'b111, "mid_rst");
        step(1'b0, 1'b1, 3'b010, "resume");
        step(1'b1, 1'b0, 3'b010, "rst_dis");

        // Random mix of reset, enable and code.
        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), "rand");

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
